// File: rtl/ssd_frame_decoder.sv
// Recovers the six BCD digits shown on a multiplexed common-anode display
// by watching the anode/cathode lines and assembling complete frames.
module ssd_frame_decoder #(
  parameter int unsigned SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  anode,
  input  logic [7:0]  cathode,
  output logic [23:0] digits,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {WAIT, SETTLING, CAPTURED} state_t;

  state_t      state;
  logic [5:0]  anode_s, anode_h;
  logic [7:0]  cathode_s, cathode_h;
  logic [7:0]  cnt;
  logic [23:0] shadow, shadow_nx;
  logic [5:0]  seen, seen_nx;

  logic        changed, stable_done, capture, multi;
  logic [3:0]  value;
  logic [2:0]  low_count;
  int unsigned idx;

  function automatic logic [3:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40:   decode = 4'd0;
      7'h79:   decode = 4'd1;
      7'h24:   decode = 4'd2;
      7'h30:   decode = 4'd3;
      7'h19:   decode = 4'd4;
      7'h12:   decode = 4'd5;
      7'h02:   decode = 4'd6;
      7'h78:   decode = 4'd7;
      7'h00:   decode = 4'd8;
      7'h10:   decode = 4'd9;
      default: decode = 4'hF;
    endcase
  endfunction

  always_comb begin
    changed     = (anode_s != anode_h) || (cathode_s != cathode_h);
    // The cycle that registers a change counts as the first stable sample.
    stable_done = (state == SETTLING) && !changed && (cnt == 8'(SETTLE - 2));
    low_count   = '0;
    idx         = 0;
    for (int unsigned b = 0; b < 6; b++) begin
      if (!anode_h[b]) begin
        low_count = low_count + 3'd1;
        idx       = b;
      end
    end
    capture = stable_done && (low_count == 3'd1);
    multi   = stable_done && (low_count > 3'd1);
    value   = decode(cathode_h[6:0]);

    // A completed frame clears seen, but a capture in that same cycle survives.
    seen_nx   = (seen == '1) ? '0 : seen;
    shadow_nx = shadow;
    if (capture) begin
      seen_nx[idx]          = 1'b1;
      shadow_nx[idx*4 +: 4] = value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_s     <= '1;
      cathode_s   <= '1;
      anode_h     <= '1;
      cathode_h   <= '1;
      cnt         <= '0;
      state       <= WAIT;
      shadow      <= '0;
      seen        <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      anode_s     <= anode;
      cathode_s   <= cathode;
      frame_valid <= 1'b0;

      if (changed) begin
        anode_h   <= anode_s;
        cathode_h <= cathode_s;
        cnt       <= '0;
        state     <= (anode_s == '1) ? WAIT : SETTLING;
      end else if (state == SETTLING) begin
        if (stable_done) state <= CAPTURED;
        else             cnt   <= cnt + 8'd1;
      end

      shadow <= shadow_nx;
      seen   <= seen_nx;
      if (seen == '1) begin
        digits      <= shadow;
        frame_valid <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end

      if (capture && value == 4'hF) seg_err   <= 1'b1;
      if (multi)                    anode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Directed bench for ssd_frame_decoder: scans digit patterns with chosen dwell
// times and checks frames, error flags, reset behaviour and counter wrap.
module tb_ssd_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  anode;
  logic [7:0]  cathode;
  logic [23:0] digits;
  logic        frame_valid, seg_err, anode_err;
  logic [7:0]  frame_count;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int p0;

  ssd_frame_decoder #(.SETTLE(16)) dut (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode),
    .digits(digits), .frame_valid(frame_valid), .seg_err(seg_err),
    .anode_err(anode_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a stretched pulse shows up as extra pulses.
  always @(negedge clk) if (frame_valid) pulses++;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h40; 4'd1: s = 7'h79; 4'd2: s = 7'h24; 4'd3: s = 7'h30;
      4'd4: s = 7'h19; 4'd5: s = 7'h12; 4'd6: s = 7'h02; 4'd7: s = 7'h78;
      4'd8: s = 7'h00; default: s = 7'h10;
    endcase
    return {1'b1, s};
  endfunction

  function automatic logic [5:0] sel(input int d);
    logic [5:0] one;
    one = 6'b100000;
    return ~(one >> d);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [5:0] a, input logic [7:0] c, input int n);
    anode = a;
    cathode = c;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [23:0] v, input int dwell);
    for (int d = 0; d < 6; d++) put(sel(d), seg(v[(5-d)*4 +: 4]), dwell);
  endtask

  task automatic blank(input int n);
    put(6'b111111, 8'hFF, n);
  endtask

  task automatic do_reset;
    anode = '1;
    cathode = '1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    anode = '1;
    cathode = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_digits", 32'(digits), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_anode_err", 32'(anode_err), 32'h0);
    check("rst_count", 32'(frame_count), 32'h0);

    blank(10);
    check("blank_no_frame", 32'(pulses), 32'd0);

    scan(24'h123456, 10);
    blank(4);
    check("dwell10_no_frame", 32'(pulses), 32'd0);
    check("dwell10_digits", 32'(digits), 32'h0);

    scan(24'h123456, 15);
    blank(4);
    check("dwell15_no_frame", 32'(pulses), 32'd0);

    scan(24'h123456, 20);
    blank(4);
    check("dwell20_digits", 32'(digits), 32'h123456);
    check("dwell20_pulses", 32'(pulses), 32'd1);
    check("dwell20_count", 32'(frame_count), 32'd1);

    scan(24'h654321, 16);
    blank(4);
    check("dwell16_digits", 32'(digits), 32'h654321);
    check("dwell16_pulses", 32'(pulses), 32'd2);
    check("dwell16_seg_err", 32'(seg_err), 32'h0);

    put(sel(0), seg(4'd6), 20);
    put(sel(1), seg(4'd5), 20);
    put(sel(2), 8'hFF, 20);
    put(sel(3), seg(4'd3), 20);
    put(sel(4), seg(4'd2), 20);
    put(sel(5), seg(4'd1), 20);
    blank(4);
    check("bad_seg_digits", 32'(digits), 32'h65F321);
    check("bad_seg_flag", 32'(seg_err), 32'h1);
    scan(24'h987654, 20);
    blank(4);
    check("clean_digits", 32'(digits), 32'h987654);
    check("seg_err_sticky", 32'(seg_err), 32'h1);
    check("clean_count", 32'(frame_count), 32'd4);

    check("anode_err_pre", 32'(anode_err), 32'h0);
    p0 = pulses;
    put(6'b001111, seg(4'd1), 40);
    check("anode_err_set", 32'(anode_err), 32'h1);
    put(sel(1), 8'hC0, 20);
    put(sel(2), seg(4'd1), 20);
    put(sel(3), seg(4'd2), 20);
    put(sel(4), seg(4'd3), 20);
    put(sel(5), seg(4'd4), 20);
    blank(4);
    check("anode_err_no_seen", 32'(pulses - p0), 32'd0);
    put(sel(0), 8'h40, 20);
    blank(4);
    check("dp_ignored_digits", 32'(digits), 32'h001234);
    check("dp_ignored_pulses", 32'(pulses - p0), 32'd1);
    check("anode_err_sticky", 32'(anode_err), 32'h1);

    put(sel(3), seg(4'd7), 20);
    put(sel(4), seg(4'd7), 20);
    put(sel(5), seg(4'd7), 20);
    do_reset();
    check("mid_rst_digits", 32'(digits), 32'h0);
    check("mid_rst_count", 32'(frame_count), 32'h0);
    check("mid_rst_errs", 32'({seg_err, anode_err}), 32'h0);
    p0 = pulses;
    put(sel(0), seg(4'd0), 20);
    put(sel(1), seg(4'd9), 20);
    put(sel(2), seg(4'd5), 20);
    put(sel(3), seg(4'd9), 20);
    put(sel(4), seg(4'd5), 20);
    blank(4);
    check("post_rst_5_no_frame", 32'(pulses - p0), 32'd0);
    put(sel(5), seg(4'd9), 20);
    blank(4);
    check("post_rst_6_pulses", 32'(pulses - p0), 32'd1);
    check("post_rst_digits", 32'(digits), 32'h095959);
    check("post_rst_count", 32'(frame_count), 32'd1);

    do_reset();
    p0 = pulses;
    for (int f = 0; f < 255; f++) scan(24'h123456, 17);
    blank(3);
    check("wrap_count_255", 32'(frame_count), 32'd255);
    check("wrap_pulses_255", 32'(pulses - p0), 32'd255);
    scan(24'h123456, 17);
    blank(3);
    check("wrap_count_0", 32'(frame_count), 32'd0);
    check("wrap_pulses_256", 32'(pulses - p0), 32'd256);
    check("wrap_digits", 32'(digits), 32'h123456);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
